// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator with registered syncs, position and frame counter
// Ports: clk pixel clock; rst_n async active-low reset; ena advance enable;
//        restart force return to (0,0); hsync/vsync sync pulses at SYNC_POL;
//        display_on visible pixel; hpos/vpos raster position; line_start at hpos=0;
//        frame_start at (0,0); frame_cnt frames entered, mod 256.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       restart,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);
  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_A_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_F_END = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_S_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  phase_t     h_st, v_st, h_st_n, v_st_n;
  logic [9:0] hpos_n, vpos_n;
  logic       h_wrap, v_wrap;
  // Next position and phase are computed first so every output register
  // decodes the same value the counters are about to hold (zero skew).
  always_comb begin
    h_wrap = hpos == H_LAST;
    v_wrap = vpos == V_LAST;
    hpos_n = (restart || h_wrap) ? '0 : hpos + 10'd1;
    vpos_n = (restart || (h_wrap && v_wrap)) ? '0 : h_wrap ? vpos + 10'd1 : vpos;
    h_st_n = (restart || h_wrap) ? ACTIVE :
             hpos == H_A_END ? FRONT :
             hpos == H_F_END ? SYNC :
             hpos == H_S_END ? BACK : h_st;
    v_st_n = restart ? ACTIVE :
             !h_wrap ? v_st :
             v_wrap ? ACTIVE :
             vpos == V_A_END ? FRONT :
             vpos == V_F_END ? SYNC :
             vpos == V_S_END ? BACK : v_st;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      h_st        <= BACK;
      v_st        <= BACK;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (ena) begin
      hpos        <= hpos_n;
      vpos        <= vpos_n;
      h_st        <= h_st_n;
      v_st        <= v_st_n;
      hsync       <= (h_st_n == SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_st_n == SYNC) ? SYNC_POL : ~SYNC_POL;
      display_on  <= (h_st_n == ACTIVE) && (v_st_n == ACTIVE);
      line_start  <= hpos_n == '0;
      frame_start <= (hpos_n == '0) && (vpos_n == '0);
      // Restart at (0,0) and restart on the wrap edge both count as one entry.
      if (hpos_n == '0 && vpos_n == '0) frame_cnt <= frame_cnt + 8'd1;
    end
  end
endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_POL, default 0, asserted level of hsync/vsync.
REQ-010 The block SHALL have ports: clk in 1, pixel clock; rst_n in 1, reset, asynchronous active-low.
REQ-011 The block SHALL have ports: ena in 1, advance enable; restart in 1, force frame restart.
REQ-012 The block SHALL have outputs: hsync out 1; vsync out 1; display_on out 1, pixel visible.
REQ-013 The block SHALL have outputs: hpos out 10; vpos out 10; line_start out 1; frame_start out 1; frame_cnt out 8.

Function
REQ-014 H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525) SHALL be used; hpos range 0..H_TOTAL-1, vpos range 0..V_TOTAL-1.
REQ-015 A horizontal FSM SHALL step ACTIVE (hpos 0..639) -> FRONT (640..655) -> SYNC (656..751) -> BACK (752..799) -> ACTIVE; a vertical FSM SHALL step the same states over vpos (0..479, 480..489, 490..491, 492..524).
REQ-016 On each rising clk with ena=1 and restart=0, hpos SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vpos SHALL increment, wrapping V_TOTAL-1 -> 0.
REQ-017 With ena=0, all registers and outputs SHALL hold; restart SHALL be ignored.
REQ-018 With ena=1 and restart=1, the next edge SHALL force hpos=0, vpos=0, both FSMs to ACTIVE, regardless of current position.
REQ-019 All outputs SHALL be registered and mutually consistent with the hpos/vpos value presented in the same cycle (zero skew between counters and decodes).
REQ-020 hsync SHALL equal SYNC_POL while horizontal FSM is SYNC, else ~SYNC_POL; vsync likewise for the vertical FSM (whole lines, changing when hpos=0).
REQ-021 display_on SHALL be 1 only when both FSMs are ACTIVE.
REQ-022 line_start SHALL be 1 for exactly the cycle(s) hpos=0; frame_start SHALL be 1 only when hpos=0 and vpos=0.
REQ-023 frame_cnt SHALL increment by 1 (mod 256, 255->0) on every transition into (0,0), natural wrap or restart; a restart coinciding with natural wrap SHALL increment once.
REQ-024 restart while already at (0,0) SHALL hold (0,0) and still increment frame_cnt.

Reset
REQ-025 While rst_n=0, asynchronously: hpos=H_TOTAL-1, vpos=V_TOTAL-1, FSMs=BACK, hsync=vsync=~SYNC_POL, display_on=0, line_start=0, frame_start=0, frame_cnt=0.
REQ-026 First enabled edge after rst_n rises SHALL reach (0,0) with frame_start=1, line_start=1, display_on=1, frame_cnt=1.
REQ-027 Reset asserted mid-frame SHALL take effect immediately without waiting for a clock edge.

Verification
REQ-028 Reset release, ena=1, 1 edge -> hpos=0, vpos=0, frame_start=1, display_on=1, frame_cnt=1.
REQ-029 Run 800 edges from (0,0) -> hsync low exactly at hpos 656..751 (96 cycles), display_on low at 640..799, line_start once at hpos=0, vpos=1.
REQ-030 Run full frame 420000 edges -> vsync low for lines 490..491 (1600 cycles), frame_start back at (0,0), frame_cnt=2.
REQ-031 ena=0 for 50 cycles at hpos=700 -> all outputs frozen; ena=1 -> hpos=701 next edge; restart pulsed while ena=0 -> no effect.
REQ-032 restart=1 at (300,200) -> next edge (0,0), frame_start=1, frame_cnt+1; restart at (799,524) -> frame_cnt+1 only once.
REQ-033 Force 256 frame wraps -> frame_cnt 255 -> 0; rst_n pulsed low mid-line -> outputs at reset values before next clk edge.
